// File: rtl/l3_mem_ctrl.sv
// L3-side memory controller: request FIFO, one access at a time to a fixed-latency port, periodic refresh.
// Define L3_MEM_CTRL_STATS_EN to build the read/write/refresh statistics counters.

module l3_mem_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int READ_LAT       = 2,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ref,
    output logic              busy,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_ref_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int TMR_W  = $clog2(REFRESH_PERIOD);
    localparam int WCNT_W = $clog2(READ_LAT + 1);
    localparam int RCNT_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REFRESH_PERIOD - 1);
    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(READ_LAT - 1);
    localparam logic [RCNT_W-1:0] REF_LOAD  = RCNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_REFRESH} state_t;

    state_t              state;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;
    logic                fifo_we    [FIFO_DEPTH];
    logic [ADDR_W-1:0]   fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_wdata [FIFO_DEPTH];
    logic                full, empty, push, pop;
    logic [TMR_W-1:0]    tmr;
    logic                ref_pend;
    logic [WCNT_W-1:0]   wcnt;
    logic [RCNT_W-1:0]   rcnt;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == S_ISSUE);
    assign busy      = !empty || (state != S_IDLE);

    // Request queue: storage is data-only, pointers and occupancy are reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]    <= req_write;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Refresh timer; taking the refresh wins over a coincident wrap so it is never doubled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr      <= '0;
            ref_pend <= 1'b0;
        end else begin
            tmr <= (tmr == TMR_LAST) ? '0 : tmr + 1'b1;
            if (state == S_IDLE && ref_pend)
                ref_pend <= 1'b0;
            else if (tmr == TMR_LAST)
                ref_pend <= 1'b1;
        end
    end

    // Access sequencer with registered memory and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_ref   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ref_pend) begin
                        state   <= S_REFRESH;
                        mem_ref <= 1'b1;
                        rcnt    <= REF_LOAD;
                    end else if (!empty) begin
                        state     <= S_ISSUE;
                        mem_en    <= 1'b1;
                        mem_we    <= fifo_we[rd_ptr];
                        mem_addr  <= fifo_addr[rd_ptr];
                        mem_wdata <= fifo_wdata[rd_ptr];
                    end
                end
                S_ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    if (mem_we) begin
                        state <= S_IDLE;
                    end else begin
                        wcnt  <= WAIT_LOAD;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt == '0) begin
                        rsp_rdata <= mem_rdata;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_REFRESH: begin
                    if (rcnt == '0) begin
                        mem_ref <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        rcnt <= rcnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef L3_MEM_CTRL_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, ref_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            ref_cnt <= '0;
        end else begin
            if (state == S_ISSUE && !mem_we) rd_cnt  <= rd_cnt + 1'b1;
            if (state == S_ISSUE && mem_we)  wr_cnt  <= wr_cnt + 1'b1;
            if (state == S_IDLE && ref_pend) ref_cnt <= ref_cnt + 1'b1;
        end
    end

    assign stat_rd_cnt  = rd_cnt;
    assign stat_wr_cnt  = wr_cnt;
    assign stat_ref_cnt = ref_cnt;
`else
    assign stat_rd_cnt  = '0;
    assign stat_wr_cnt  = '0;
    assign stat_ref_cnt = '0;
`endif

endmodule

// File: tb/tb_l3_mem_ctrl.sv
// Self-checking bench for l3_mem_ctrl: directed timing scenarios plus randomized traffic
// checked against an in-order transaction model with a shadow memory.

module tb_l3_mem_ctrl;

    localparam int AW = 16, DW = 32, DEPTH = 4, RL = 2, PER = 64, RCYC = 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } iss_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          mem_en, mem_we, mem_ref, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   stat_rd_cnt, stat_wr_cnt, stat_ref_cnt;

    int n_pass = 0;
    int n_total = 0;

    l3_mem_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .READ_LAT(RL),
        .REFRESH_PERIOD(PER), .REFRESH_CYCLES(RCYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ref(mem_ref), .busy(busy),
        .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_ref_cnt(stat_ref_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int a);
        if (a == 16) return 32'hDEADBEEF;
        return 32'hC0DE0000 ^ (32'(a) * 32'h00010101);
    endfunction

    // Fixed-latency memory: contents reload on reset, reads return READ_LAT cycles after mem_en
    logic [31:0] mem_arr [256];
    logic        dl_v [RL];
    logic [7:0]  dl_a [RL];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
            for (int k = 0; k < RL; k++) begin
                dl_v[k] <= 1'b0;
                dl_a[k] <= 8'h0;
            end
        end else begin
            if (mem_en && mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
            dl_v[0] <= mem_en && !mem_we;
            dl_a[0] <= mem_addr[7:0];
            for (int k = 1; k < RL; k++) begin
                dl_v[k] <= dl_v[k-1];
                dl_a[k] <= dl_a[k-1];
            end
        end
    end

    assign mem_rdata = dl_v[RL-1] ? mem_arr[dl_a[RL-1]] : 32'hBADC0FFE;

    // Leaves the bench at the negedge inside cycle 0 after release
    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({req_ready, busy, mem_en, mem_we, mem_ref, rsp_valid} !== 6'b100000)
            $display("FAIL reset_ctrl: got %b expected 100000", {req_ready, busy, mem_en, mem_we, mem_ref, rsp_valid});
        else n_pass++;
        n_total++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 80'h0)
            $display("FAIL reset_data: got addr %h wdata %h rdata %h expected all 0", mem_addr, mem_wdata, rsp_rdata);
        else n_pass++;
        n_total++;
        if ({stat_rd_cnt, stat_wr_cnt, stat_ref_cnt} !== 48'h0)
            $display("FAIL reset_stats: got %h expected 0", {stat_rd_cnt, stat_wr_cnt, stat_ref_cnt});
        else n_pass++;
    endtask

    task automatic test_single_read();
        logic exp_en, exp_rv;
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010; req_wdata = '0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            exp_en = (c == 2);
            exp_rv = (c == 5);
            n_total++;
            if ({mem_en, mem_we, rsp_valid} !== {exp_en, 1'b0, exp_rv})
                $display("FAIL read_timing c%0d: got en/we/rv %b expected %b", c, {mem_en, mem_we, rsp_valid}, {exp_en, 1'b0, exp_rv});
            else n_pass++;
            if (c == 2) begin
                n_total++;
                if (mem_addr !== 16'h0010) $display("FAIL read_addr: got %h expected 0010", mem_addr);
                else n_pass++;
            end
            if (c == 5) begin
                n_total++;
                if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL read_data: got %h expected deadbeef", rsp_rdata);
                else n_pass++;
            end
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL read_idle_busy: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_single_write();
        logic exp_en;
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 32'h12345678;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            exp_en = (c == 2);
            n_total++;
            if ({mem_en, mem_we, rsp_valid} !== {exp_en, exp_en, 1'b0})
                $display("FAIL write_timing c%0d: got en/we/rv %b expected %b", c, {mem_en, mem_we, rsp_valid}, {exp_en, exp_en, 1'b0});
            else n_pass++;
            if (c == 2) begin
                n_total++;
                if ({mem_addr, mem_wdata} !== {16'h0020, 32'h12345678})
                    $display("FAIL write_addr_data: got %h/%h expected 0020/12345678", mem_addr, mem_wdata);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rsp_ready = 1'b0;
        fork
            begin
                logic rdy, ok;
                int guard;
                for (int i = 0; i < 6; i++) begin
                    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'(16'h0040 + i);
                    ok = 1'b0; guard = 0;
                    while (!ok && guard < 100) begin
                        rdy = req_ready;
                        if (i == 5 && guard == 0) begin
                            n_total++;
                            if (rdy !== 1'b0) $display("FAIL b2b_full: got req_ready %b expected 0", rdy);
                            else n_pass++;
                        end
                        @(negedge clk);
                        ok = rdy;
                        guard++;
                    end
                    if (!ok) begin
                        n_total++;
                        $display("FAIL b2b_push_timeout: request %0d not accepted, expected acceptance", i);
                    end
                end
                req_valid = 1'b0;
            end
            begin
                int guard;
                repeat (10) @(negedge clk);
                rsp_ready = 1'b1;
                for (int j = 0; j < 6; j++) begin
                    guard = 0;
                    while (rsp_valid !== 1'b1 && guard < 60) begin
                        @(negedge clk);
                        guard++;
                    end
                    n_total++;
                    if (rsp_valid !== 1'b1 || rsp_rdata !== init_val(16'h40 + j))
                        $display("FAIL b2b_rsp%0d: got valid %b data %h expected 1/%h", j, rsp_valid, rsp_rdata, init_val(16'h40 + j));
                    else n_pass++;
                    @(negedge clk);
                end
            end
        join
    endtask

    task automatic test_refresh();
        logic exp_ref;
        do_reset();
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            exp_ref = (c >= 65) && (((c - 65) % PER) < RCYC);
            n_total++;
            if (mem_ref !== exp_ref) $display("FAIL refresh_c%0d: got mem_ref %b expected %b", c, mem_ref, exp_ref);
            else n_pass++;
        end
    endtask

    task automatic test_refresh_vs_read();
        logic exp_en, exp_ref, exp_rv;
        do_reset();
        rsp_ready = 1'b1;
        repeat (60) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0050;
        for (int c = 61; c <= 78; c++) begin
            @(negedge clk);
            if (c == 61) req_addr = 16'h0051;
            else req_valid = 1'b0;
            exp_en  = (c == 62) || (c == 70);
            exp_ref = (c == 67) || (c == 68);
            exp_rv  = (c == 65) || (c == 73);
            n_total++;
            if ({mem_en, mem_ref, rsp_valid} !== {exp_en, exp_ref, exp_rv})
                $display("FAIL ref_vs_read_c%0d: got en/ref/rv %b expected %b", c, {mem_en, mem_ref, rsp_valid}, {exp_en, exp_ref, exp_rv});
            else n_pass++;
            if (c == 65 || c == 73) begin
                n_total++;
                if (rsp_rdata !== init_val((c == 65) ? 16'h50 : 16'h51))
                    $display("FAIL ref_vs_read_data_c%0d: got %h expected %h", c, rsp_rdata, init_val((c == 65) ? 16'h50 : 16'h51));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0060;
        @(negedge clk); req_addr = 16'h0061;
        @(negedge clk); req_addr = 16'h0062;
        @(negedge clk); req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({mem_en, mem_we, mem_ref, rsp_valid, busy, req_ready} !== 6'b000001)
            $display("FAIL midreset_ctrl: got %b expected 000001", {mem_en, mem_we, mem_ref, rsp_valid, busy, req_ready});
        else n_pass++;
        n_total++;
        if ({mem_addr, rsp_rdata} !== 48'h0) $display("FAIL midreset_data: got %h/%h expected 0/0", mem_addr, rsp_rdata);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            n_total++;
            if ({rsp_valid, mem_en, busy, req_ready} !== 4'b0001)
                $display("FAIL midreset_after_c%0d: got rv/en/busy/rdy %b expected 0001", c, {rsp_valid, mem_en, busy, req_ready});
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_stats();
        logic [15:0] exp_rd, exp_wr, exp_ref;
        logic rdy, ok;
        int cyc, guard;
        do_reset();
        rsp_ready = 1'b1;
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_write = i[0]; req_addr = 16'(16'h0070 + i); req_wdata = 32'(i);
            ok = 1'b0; guard = 0;
            while (!ok && guard < 40) begin
                rdy = req_ready;
                @(negedge clk);
                cyc++;
                ok = rdy;
                guard++;
            end
        end
        req_valid = 1'b0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
`ifdef L3_MEM_CTRL_STATS_EN
        exp_rd = 16'd3; exp_wr = 16'd2; exp_ref = 16'd1;
`else
        exp_rd = 16'd0; exp_wr = 16'd0; exp_ref = 16'd0;
`endif
        n_total++;
        if ({stat_rd_cnt, stat_wr_cnt, stat_ref_cnt} !== {exp_rd, exp_wr, exp_ref})
            $display("FAIL stats: got %0d/%0d/%0d expected %0d/%0d/%0d", stat_rd_cnt, stat_wr_cnt, stat_ref_cnt, exp_rd, exp_wr, exp_ref);
        else n_pass++;
    endtask

    task automatic test_random();
        iss_t        exp_iss[$];
        logic [31:0] exp_rsp[$];
        logic [31:0] ref_mem [256];
        iss_t        e;
        logic [31:0] exp_d;
        logic        prev_hold;
        logic [31:0] prev_data;
        int          ref_run;
        bit          draining, done;
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        prev_hold = 1'b0; prev_data = '0; ref_run = 0; done = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            draining = (cyc >= 1200);
            if (mem_en === 1'b1) begin
                n_total++;
                if (exp_iss.size() == 0) begin
                    $display("FAIL rnd_issue_extra: got access to %h expected none", mem_addr);
                end else begin
                    e = exp_iss.pop_front();
                    if ({mem_we, mem_addr} !== {e.we, e.a} || (e.we && mem_wdata !== e.d))
                        $display("FAIL rnd_issue: got we %b addr %h data %h expected we %b addr %h data %h", mem_we, mem_addr, mem_wdata, e.we, e.a, e.d);
                    else n_pass++;
                end
            end
            if (mem_ref === 1'b1) begin
                ref_run++;
                n_total++;
                if ({mem_en, rsp_valid} !== 2'b00) $display("FAIL rnd_ref_overlap: got en/rv %b expected 00", {mem_en, rsp_valid});
                else n_pass++;
            end else if (ref_run != 0) begin
                n_total++;
                if (ref_run != RCYC) $display("FAIL rnd_ref_len: got %0d expected %0d", ref_run, RCYC);
                else n_pass++;
                ref_run = 0;
            end
            if (prev_hold) begin
                n_total++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== prev_data)
                    $display("FAIL rnd_rsp_hold: got valid %b data %h expected 1/%h", rsp_valid, rsp_rdata, prev_data);
                else n_pass++;
            end
            if (draining) begin
                req_valid = 1'b0;
                rsp_ready = 1'b1;
            end else begin
                req_valid = ($urandom_range(99) < 50);
                req_write = ($urandom_range(99) < 40);
                req_addr  = 16'($urandom_range(31));
                req_wdata = $urandom;
                rsp_ready = ($urandom_range(99) < 70);
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                n_total++;
                if (exp_rsp.size() == 0) begin
                    $display("FAIL rnd_rsp_extra: got %h expected no response", rsp_rdata);
                end else begin
                    exp_d = exp_rsp.pop_front();
                    if (rsp_rdata !== exp_d) $display("FAIL rnd_rsp: got %h expected %h", rsp_rdata, exp_d);
                    else n_pass++;
                end
            end
            if (req_valid && req_ready === 1'b1) begin
                e.we = req_write; e.a = req_addr; e.d = req_wdata;
                exp_iss.push_back(e);
                if (req_write) ref_mem[req_addr[7:0]] = req_wdata;
                else exp_rsp.push_back(ref_mem[req_addr[7:0]]);
            end
            prev_hold = (rsp_valid === 1'b1) && !rsp_ready;
            prev_data = rsp_rdata;
            if (draining && busy === 1'b0 && exp_iss.size() == 0 && exp_rsp.size() == 0) done = 1;
            @(negedge clk);
        end
        n_total++;
        if (!done) $display("FAIL rnd_drain: got %0d issues %0d responses outstanding expected 0/0", exp_iss.size(), exp_rsp.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_refresh();
        test_refresh_vs_read();
        test_reset_mid_wait();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
